// File: rtl/mul_iter_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
package mul_iter_pkg;

  // Controller states, 2-bit encoding.
  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_SIGN = 2'd2,
    MUL_DONE = 2'd3
  } mul_state_e;

  // Step counter width: must hold WIDTH-1.
  function automatic int mul_cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/mul_iter_elem.sv
// One radix-2 partial-product step: conditional add of the multiplicand
// into the upper half, then a one-bit logical right shift of the whole
// accumulator. Purely combinational.
module mul_iter_elem #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   acc_hi_i,
  input  logic [WIDTH-1:0] acc_lo_i,
  input  logic [WIDTH-1:0] mag_a_i,
  output logic [WIDTH:0]   acc_hi_o,
  output logic [WIDTH-1:0] acc_lo_o
);

  logic [WIDTH:0] addend;
  logic [WIDTH:0] sum;

  // Add magA when the current multiplier bit is set, then shift right by one.
  always_comb begin
    addend   = acc_lo_i[0] ? {1'b0, mag_a_i} : '0;
    sum      = acc_hi_i + addend;
    acc_hi_o = {1'b0, sum[WIDTH:1]};
    acc_lo_o = {sum[0], acc_lo_i[WIDTH-1:1]};
  end

endmodule

// File: rtl/mul_iter.sv
// Iterative radix-2 multiplier for mullw/mulhw/mulhwu. Operands are reduced
// to magnitudes at load, WIDTH shift-add steps build the unsigned product,
// and a final SIGN cycle applies the two's-complement fix-up.
module mul_iter
  import mul_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo
);

  localparam int CW = mul_cnt_w(WIDTH);
  localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W   = (2*WIDTH)'(1);

  mul_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   mag_a_q, mag_a_d;
  logic               neg_q, neg_d;
  logic [WIDTH:0]     acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic [WIDTH:0]     step_hi;
  logic [WIDTH-1:0]   step_lo;
  logic               load;
  logic [2*WIDTH-1:0] acc_cat;

  mul_iter_elem #(.WIDTH(WIDTH)) u_elem (
    .acc_hi_i (acc_hi_q),
    .acc_lo_i (acc_lo_q),
    .mag_a_i  (mag_a_q),
    .acc_hi_o (step_hi),
    .acc_lo_o (step_lo)
  );

  // A new op is accepted only when the unit is idle or just finished.
  assign load = start && (state_q == MUL_IDLE || state_q == MUL_DONE);

  // After WIDTH steps acc_hi's top bit is always clear, so the product
  // is the low WIDTH bits of acc_hi concatenated with acc_lo.
  assign acc_cat = {acc_hi_q[WIDTH-1:0], acc_lo_q};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= MUL_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MUL_IDLE: if (start) state_d = MUL_RUN;
      MUL_RUN:  if (cnt_q == CNT_LAST) state_d = MUL_SIGN;
      MUL_SIGN: state_d = MUL_DONE;
      MUL_DONE: state_d = start ? MUL_RUN : MUL_IDLE;
      default:  state_d = MUL_IDLE;
    endcase
  end

  // Status outputs decoded from state; product comes straight from its register.
  always_comb begin
    busy    = (state_q == MUL_RUN) || (state_q == MUL_SIGN);
    done    = (state_q == MUL_DONE);
    prod_hi = prod_q[2*WIDTH-1:WIDTH];
    prod_lo = prod_q[WIDTH-1:0];
  end

  // Datapath next values: load, shift-add step, sign fix-up.
  always_comb begin
    cnt_d    = cnt_q;
    mag_a_d  = mag_a_q;
    neg_d    = neg_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    prod_d   = prod_q;
    if (load) begin
      // Magnitudes are unsigned WIDTH-bit values; |MIN_INT| fits as 2^(WIDTH-1).
      mag_a_d  = (signed_op && srcA[WIDTH-1]) ? (~srcA + ONE_W) : srcA;
      acc_lo_d = (signed_op && srcB[WIDTH-1]) ? (~srcB + ONE_W) : srcB;
      acc_hi_d = '0;
      neg_d    = signed_op && (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
      cnt_d    = '0;
    end else if (state_q == MUL_RUN) begin
      acc_hi_d = step_hi;
      acc_lo_d = step_lo;
      cnt_d    = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_ONE;
    end else if (state_q == MUL_SIGN) begin
      prod_d   = neg_q ? (~acc_cat + ONE_2W) : acc_cat;
    end
  end

  // Counter, operand and accumulator registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      mag_a_q  <= '0;
      neg_q    <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      mag_a_q  <= mag_a_d;
      neg_q    <= neg_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
    end
  end

  // Product register: written only on the SIGN edge, held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prod_q <= '0;
    else     prod_q <= prod_d;
  end

  // busy and done are mutually exclusive by construction of the decode.
  a_busy_done_excl: assert property (@(posedge clk) disable iff (rst) !(busy && done));

endmodule

// File: tb/tb_mul_iter.sv
// Scoreboard bench for mul_iter: drivers push expected product and due
// cycle, a negedge monitor pops on each done pulse and compares.
module tb_mul_iter;
  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         signed_op = 1'b0;
  logic [W-1:0] srcA = '0;
  logic [W-1:0] srcB = '0;
  logic         busy, done;
  logic [W-1:0] prod_hi, prod_lo;

  mul_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
    .srcA(srcA), .srcB(srcB), .busy(busy), .done(done),
    .prod_hi(prod_hi), .prod_lo(prod_lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] prod;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] x, y;
    x = s ? {{32{a[31]}}, a} : {32'h0, a};
    y = s ? {{32{b[31]}}, b} : {32'h0, b};
    return x * y;
  endfunction

  // Monitor: exclusivity every cycle, result and latency on each done.
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy_done_overlap", {63'h0, busy & done}, 64'h0);
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'h1, 64'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("product", {prod_hi, prod_lo}, e.prod);
          chk("latency_cycle", 64'(cyc), 64'(e.due));
        end
      end
    end
  end

  // Drive operands and start now; result due LAT cycles later unless overridden.
  task automatic launch(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [63:0] exp, input int due);
    exp_t e;
    signed_op = s; srcA = a; srcB = b; start = 1'b1;
    e.prod = exp; e.due = due;
    sb.push_back(e);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk); #1; t++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 64'(sb.size()), 64'h0);
      sb.delete();
    end
  endtask

  task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [63:0] exp);
    launch(s, a, b, exp, cyc + LAT);
    @(negedge clk); #1;
    start = 1'b0;
    drain();
  endtask

  initial begin
    int k;
    logic [W-1:0] corners [6];
    corners[0] = 32'h0000_0000; corners[1] = 32'hFFFF_FFFF; corners[2] = 32'h8000_0000;
    corners[3] = 32'h7FFF_FFFF; corners[4] = 32'h0000_0001; corners[5] = 32'h8000_0001;

    // Reset state.
    #1;
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_done", {63'h0, done}, 64'h0);
    chk("rst_prod", {prod_hi, prod_lo}, 64'h0);
    @(negedge clk); @(negedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;

    // Directed vectors.
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_op(1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_op(1'b0, 32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000);
    run_op(1'b1, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000);
    run_op(1'b0, 32'h0000_0000, 32'h1234_5678, 64'h0);

    // start pulsed mid-run with other operands must be ignored.
    launch(1'b0, 32'h0001_0000, 32'h0000_0010, 64'h0000_0000_0010_0000, cyc + LAT);
    @(negedge clk); #1; start = 1'b0;
    repeat (9) @(negedge clk);
    #1; signed_op = 1'b1; srcA = 32'hDEAD_BEEF; srcB = 32'h0BAD_F00D; start = 1'b1;
    @(negedge clk); #1; start = 1'b0;
    drain();

    // Asynchronous reset mid-operation, then a clean 7*6.
    launch(1'b0, 32'h1111_1111, 32'h0000_0003, 64'h3333_3333, cyc + LAT);
    @(negedge clk); #1; start = 1'b0;
    repeat (15) @(negedge clk);
    #2; rst = 1'b1;
    #1;
    chk("arst_busy", {63'h0, busy}, 64'h0);
    chk("arst_done", {63'h0, done}, 64'h0);
    chk("arst_prod", {prod_hi, prod_lo}, 64'h0);
    sb.delete();
    @(negedge clk); #1; rst = 1'b0;
    @(negedge clk); #1;
    run_op(1'b0, 32'd7, 32'd6, 64'd42);

    // start held through DONE: back-to-back, prod holds first result meanwhile.
    k = cyc;
    launch(1'b0, 32'd3, 32'd4, 64'd12, k + LAT);
    @(negedge clk); #1;
    launch(1'b1, 32'hFFFF_FFFB, 32'd6, 64'hFFFF_FFFF_FFFF_FFE2, k + 2*LAT);
    while (cyc < k + LAT + 1) begin @(negedge clk); #1; end
    start = 1'b0;
    while (cyc < k + 50) begin @(negedge clk); #1; end
    chk("b2b_hold_mid", {prod_hi, prod_lo}, 64'd12);
    while (cyc < k + 2*LAT - 1) begin @(negedge clk); #1; end
    chk("b2b_hold_presign", {prod_hi, prod_lo}, 64'd12);
    drain();

    // Random operands against the 64-bit reference product.
    for (int i = 0; i < 300; i++) begin
      logic         s;
      logic [W-1:0] a, b;
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 5) == 0) a = corners[$urandom_range(0, 5)];
      if ($urandom_range(0, 5) == 0) b = corners[$urandom_range(0, 5)];
      run_op(s, a, b, model(s, a, b));
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
